// File: rtl/maze_path_stack.sv
// rtl/maze_path_stack.sv - path stack with overflow/underflow flags and bottom-to-top replay
module maze_path_stack #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_adr,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              replay_start,
  input  logic              finish,
  input  logic              move_ready,
  output logic [DATA_W-1:0] top_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              busy,
  output logic              move_valid,
  output logic [DATA_W-1:0] move_data,
  output logic              replay_done,
  output logic              replay_abort
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]     count_m1;
  logic [ADDR_W-1:0]   top_idx;
  logic [ADDR_W-1:0]   wr_idx;
  logic                do_write;

  assign count_m1 = count - 1'b1;
  assign top_idx  = count_m1[ADDR_W-1:0];

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign busy        = (state != IDLE);
  assign move_valid  = (state == REPLAY);
  assign replay_done = (state == DONE);
  assign top_data    = empty ? '0 : mem[top_idx];
  assign move_data   = move_valid ? mem[rd_idx] : '0;

  // Storage write decode: push&pop overwrites the top, a plain push appends unless full.
  always_comb begin
    do_write = 1'b0;
    wr_idx   = count[ADDR_W-1:0];
    if (!rst_adr && !clear && state == IDLE && push) begin
      if (pop && !empty) begin
        do_write = 1'b1;
        wr_idx   = top_idx;
      end else if (!full) begin
        do_write = 1'b1;
      end
    end
  end

  // Path storage array; deliberately not reset, contents only valid below count.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= push_data;
  end

  // Depth counter, sticky error flags and replay state machine.
  always_ff @(posedge clk or posedge rst_adr) begin
    if (rst_adr) begin
      state        <= IDLE;
      count        <= '0;
      rd_idx       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      replay_abort <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      count        <= '0;
      rd_idx       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      replay_abort <= 1'b0;
    end else begin
      replay_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (push && pop) begin
            if (empty) count <= count + 1'b1;
          end else if (push) begin
            if (full) overflow <= 1'b1;
            else      count    <= count + 1'b1;
          end else if (pop) begin
            if (empty) underflow <= 1'b1;
            else       count     <= count_m1;
          end else if (replay_start) begin
            rd_idx <= '0;
            state  <= empty ? DONE : REPLAY;
          end
        end
        REPLAY: begin
          // finish wins over a same-cycle handshake; that beat is dropped
          if (finish) begin
            state        <= IDLE;
            rd_idx       <= '0;
            replay_abort <= 1'b1;
          end else if (move_ready) begin
            if ({1'b0, rd_idx} == count_m1) begin
              state  <= DONE;
              rd_idx <= '0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_stack.sv
// tb/tb_maze_path_stack.sv - randomized self-checking bench against a queue-based path model
module tb_maze_path_stack;

  localparam int DEPTH = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_adr = 1'b1;
  logic          clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          replay_start = 1'b0, finish = 1'b0, move_ready = 1'b0;
  logic [DW-1:0] top_data, move_data;
  logic [2:0]    count;
  logic          empty, full, overflow, underflow, busy, move_valid, replay_done, replay_abort;

  int n_total = 0;
  int n_bad = 0;

  // reference model: the path as a queue, a replay cursor and a phase
  logic [DW-1:0] m_stk[$];
  logic          m_ovf, m_udf, m_abort;
  int            m_mode;  // 0 idle, 1 replaying, 2 done pulse
  int            m_pos;

  maze_path_stack #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst_adr(rst_adr), .clear(clear), .push(push), .pop(pop),
    .push_data(push_data), .replay_start(replay_start), .finish(finish),
    .move_ready(move_ready), .top_data(top_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow), .busy(busy),
    .move_valid(move_valid), .move_data(move_data), .replay_done(replay_done),
    .replay_abort(replay_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_ovf = 0; m_udf = 0; m_abort = 0; m_mode = 0; m_pos = 0;
  endtask

  task automatic model_step();
    int n;
    n = m_stk.size();
    if (clear) begin
      model_reset();
      return;
    end
    m_abort = 0;
    case (m_mode)
      0: begin
        if (push && pop) begin
          if (n > 0) m_stk[n-1] = push_data;
          else       m_stk.push_back(push_data);
        end else if (push) begin
          if (n == DEPTH) m_ovf = 1;
          else            m_stk.push_back(push_data);
        end else if (pop) begin
          if (n == 0) m_udf = 1;
          else        void'(m_stk.pop_back());
        end else if (replay_start) begin
          m_pos  = 0;
          m_mode = (n == 0) ? 2 : 1;
        end
      end
      1: begin
        if (finish) begin
          m_mode = 0; m_abort = 1;
        end else if (move_ready) begin
          m_pos++;
          if (m_pos == n) m_mode = 2;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_all();
    int n;
    n = m_stk.size();
    check("count", count, n);
    check("top_data", top_data, (n > 0) ? m_stk[n-1] : 0);
    check("empty", empty, n == 0);
    check("full", full, n == DEPTH);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    check("busy", busy, m_mode != 0);
    check("move_valid", move_valid, m_mode == 1);
    check("move_data", move_data, (m_mode == 1) ? m_stk[m_pos] : 0);
    check("replay_done", replay_done, m_mode == 2);
    check("replay_abort", replay_abort, m_abort);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic p, input logic po, input logic [DW-1:0] d,
                       input logic st, input logic fi, input logic rdy);
    push = p; pop = po; push_data = d; replay_start = st; finish = fi; move_ready = rdy;
    clear = 1'b0;
    cycle();
  endtask

  task automatic do_clear();
    push = 0; pop = 0; replay_start = 0; finish = 0; move_ready = 0; clear = 1;
    cycle();
    clear = 0;
  endtask

  logic [DW-1:0] held;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_adr = 1'b0;

    // fill, then overflow
    drive(1, 0, 8'h11, 0, 0, 0);
    drive(1, 0, 8'h22, 0, 0, 0);
    drive(1, 0, 8'h33, 0, 0, 0);
    drive(1, 0, 8'h44, 0, 0, 0);
    check("full_cnt", count, 4);
    check("full_top", top_data, 8'h44);
    drive(1, 0, 8'h55, 0, 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_top", top_data, 8'h44);
    do_clear();
    check("clr_ovf", overflow, 0);
    check("clr_cnt", count, 0);

    // underflow, then push&pop on empty and on non-empty
    drive(0, 1, 8'h00, 0, 0, 0);
    check("udf_set", underflow, 1);
    drive(1, 1, 8'h7A, 0, 0, 0);
    check("pp_empty", top_data, 8'h7A);
    drive(1, 1, 8'h7B, 0, 0, 0);
    check("pp_over_top", top_data, 8'h7B);
    check("pp_over_cnt", count, 1);
    do_clear();

    // full-speed replay of 3 entries
    drive(1, 0, 8'h11, 0, 0, 0);
    drive(1, 0, 8'h22, 0, 0, 0);
    drive(1, 0, 8'h33, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 1);
    check("rp_first", move_data, 8'h11);
    drive(0, 0, 8'h00, 0, 0, 1);
    check("rp_second", move_data, 8'h22);
    drive(0, 0, 8'h00, 0, 0, 1);
    check("rp_third", move_data, 8'h33);
    drive(0, 0, 8'h00, 0, 0, 1);
    check("rp_done", replay_done, 1);
    check("rp_keep_cnt", count, 3);
    drive(0, 0, 8'h00, 0, 0, 0);

    // stalled replay with push attempts during REPLAY
    drive(0, 0, 8'h00, 1, 0, 0);
    drive(1, 0, 8'h99, 0, 0, 1);
    held = move_data;
    drive(1, 0, 8'h99, 0, 0, 0);
    check("stall_hold", move_data, held);
    drive(1, 0, 8'h99, 0, 0, 0);
    check("stall_hold2", move_data, held);
    drive(1, 0, 8'h99, 0, 0, 1);
    drive(1, 0, 8'h99, 0, 0, 1);
    check("stall_done", replay_done, 1);
    check("stall_cnt", count, 3);
    check("stall_ovf", overflow, 0);
    drive(0, 0, 8'h00, 0, 0, 0);

    // abort after the first beat, then restart from the bottom
    drive(0, 0, 8'h00, 1, 0, 1);
    drive(0, 0, 8'h00, 0, 0, 1);
    drive(0, 0, 8'h00, 0, 1, 1);
    check("abort_pulse", replay_abort, 1);
    check("abort_busy", busy, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    check("restart_first", move_data, 8'h11);

    // empty replay
    do_clear();
    drive(0, 0, 8'h00, 1, 0, 1);
    check("empty_rp_done", replay_done, 1);
    check("empty_rp_valid", move_valid, 0);
    drive(0, 0, 8'h00, 0, 0, 0);

    // asynchronous reset in the middle of a replay
    drive(0, 1, 8'h00, 0, 0, 0);
    drive(1, 0, 8'h21, 0, 0, 0);
    drive(1, 0, 8'h42, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    #1 rst_adr = 1'b1;
    #1;
    model_reset();
    check("arst_cnt", count, 0);
    check("arst_valid", move_valid, 0);
    check("arst_udf", underflow, 0);
    check("arst_busy", busy, 0);
    #1 rst_adr = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      push = ($urandom_range(0, 99) < 35);
      pop = ($urandom_range(0, 99) < 25);
      push_data = 8'($urandom_range(0, 255));
      replay_start = ($urandom_range(0, 99) < 15);
      finish = ($urandom_range(0, 99) < 5);
      move_ready = ($urandom_range(0, 99) < 60);
      clear = ($urandom_range(0, 99) < 2);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_path_stack.md
# maze_path_stack

Parametrised path stack for the rat-in-maze solver. It stores the coordinates of the current path on push/pop commands from the maze walker, and flags overflow and underflow. After the solve, it replays the stored path from the entrance (bottom) to the exit (top) over a valid/ready handshake to the path display/mover. It replaces the fixed-width controller strobes with an owned storage array, a depth counter and a replay state machine.

## Interface
- DEPTH, 256, number of stack entries (≥2)
- DATA_W, 8, width of one stored coordinate word
- ADDR_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_adr  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear: count=0, flags=0, state IDLE
- push  in  1  push push_data (IDLE only)
- pop  in  1  remove top entry (IDLE only)
- push_data  in  DATA_W  coordinate to push
- replay_start  in  1  start path replay (IDLE only)
- finish  in  1  abort replay
- move_ready  in  1  consumer accepts move_data
- top_data  out  DATA_W  entry at count-1; 0 when empty (combinational from state)
- count  out  ADDR_W+1  number of stored entries
- empty, full  out  1  count==0 / count==DEPTH
- overflow, underflow  out  1  sticky error flags
- busy  out  1  state ≠ IDLE
- move_valid  out  1  move_data valid (REPLAY)
- move_data  out  DATA_W  mem[rd_idx]
- replay_done  out  1  one-cycle pulse, replay completed
- replay_abort  out  1  one-cycle pulse, replay aborted by finish

## Operation
- Storage: DEPTH×DATA_W register array. It is not reset; contents are undefined until written.
- States: IDLE, REPLAY, DONE.
- IDLE, by priority:
  - push&pop, non-empty: overwrite mem[count-1] with push_data; count unchanged.
  - push&pop, empty: plain push.
  - push, not full: mem[count]=push_data, count+1.
  - push, full: no write, overflow←1.
  - pop, not empty: count-1 (data left in place).
  - pop, empty: underflow←1.
  - replay_start with count>0: rd_idx←0, go to REPLAY.
  - replay_start with count==0: go to DONE.
  - replay_start is ignored if push or pop is asserted in the same cycle.
- REPLAY:
  - move_valid=1.
  - On move_valid&move_ready: rd_idx+1. If rd_idx==count-1, go to DONE.
  - push, pop and replay_start are ignored; no flags change. Stack contents are preserved.
  - finish=1 → IDLE next edge, replay_abort=1 for that cycle. finish has priority over a same-cycle handshake; the beat is not counted.
- DONE: replay_done=1 for one cycle, then IDLE.
- clear: dominates every input except reset; acts in any state; no done/abort pulse.
- Sticky flags clear only on rst_adr or clear.

## Timing
- Reset values: count=0, empty=1, full=0, overflow=0, underflow=0, busy=0, move_valid=0, move_data=0, top_data=0, replay_done=0, replay_abort=0, state IDLE, rd_idx=0.
- Reset asserted mid-replay: all outputs return to reset values immediately (asynchronous). Deassertion is synchronised by the integrator.
- push/pop: count, full/empty and top_data update after the sampling edge (1-cycle latency). Flags set on that same edge.
- Replay:
  - replay_start at edge N → move_valid=1 and move_data=mem[0] from edge N.
  - One beat per cycle max; move_data holds stable while move_valid&!move_ready.
  - Last beat accepted at edge M → move_valid=0 and replay_done=1 during cycle M..M+1; busy=0 from M+1.
  - Empty replay: replay_done one cycle after the start edge, move_valid never asserts.
- Arithmetic: count is ADDR_W+1 bits, so DEPTH is representable; rd_idx is ADDR_W bits; no wrap-around is permitted (guarded by full/empty).

## Test plan
(DEPTH=4, DATA_W=8 throughout)
- Push 0x11,0x22,0x33,0x44 → count=4, full=1, top_data=0x44. Fifth push 0x55 → count=4, overflow=1, top_data=0x44.
- From reset: pop → underflow=1, count=0. Then push&pop with 0x7A → count=1, top_data=0x7A. Push&pop with 0x7B → count=1, top_data=0x7B.
- Stack 0x11,0x22,0x33; replay_start, move_ready=1 → move_data 0x11,0x22,0x33 on consecutive cycles, replay_done one cycle after last beat, count still 3.
- Same stack, move_ready toggled 1,0,0,1,1 → exactly 3 beats, move_data stable while stalled; push during REPLAY → count unchanged, overflow=0.
- Replay with 3 entries, finish asserted after first beat with move_ready=1 → replay_abort pulse, move_valid=0, busy=0, no replay_done; new replay restarts at 0x11.
- rst_adr pulsed mid-REPLAY between clock edges → count=0, move_valid=0, flags=0 before the next edge. Separately, clear after overflow → overflow=0, count=0.
